// File: rtl/terrain_column_store_if.sv
// Terrain store bus: read address / pixel row from the raster, column mask back,
// plus the write-back path used by the deforming blocks.
//   DrawX         read column address (>= COLS means horizontal blank)
//   DrawY         row selecting terrain_pixel
//   terrain_data  512-bit column mask, bit y = 1 means solid
//   terrain_pixel terrain_data[DrawY] for the registered read
//   wb_data       modified column to commit
//   wb_en         commit wb_data to the previously read column
//   busy          high while the store fills itself with the initial landscape
interface terrain_column_store_if;
    logic [9:0]   DrawX;
    logic [9:0]   DrawY;
    logic [511:0] terrain_data;
    logic         terrain_pixel;
    logic [511:0] wb_data;
    logic         wb_en;
    logic         busy;

    modport master (
        output DrawX, DrawY, wb_data, wb_en,
        input  terrain_data, terrain_pixel, busy
    );

    modport slave (
        input  DrawX, DrawY, wb_data, wb_en,
        output terrain_data, terrain_pixel, busy
    );
endinterface

// File: rtl/terrain_column_store.sv
// Column-organized terrain bitmap. After reset it writes the initial landscape one
// column per clock (busy = 1), then serves one registered read plus one write-back
// per clock. A write-back always targets the column read in the previous cycle and
// is forwarded to a same-cycle read of that column so read-modify-write accumulates.
// Optional feature macro: TERRAIN_HILLS_EN selects a triangle-wave hill profile;
// without it every column starts as flat ground at GROUND_Y.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset (restarts the fill from column 0)
//   bus    terrain_column_store_if.slave (DrawX, DrawY, terrain_data, terrain_pixel,
//          wb_data, wb_en, busy)
module terrain_column_store #(
    parameter int unsigned COLS     = 640,
    parameter int unsigned GROUND_Y = 400,
    parameter int unsigned HILL_AMP = 32
) (
    input logic                   clk,
    input logic                   reset,
    terrain_column_store_if.slave bus
);
    localparam int unsigned DataW      = 512;
    localparam int unsigned SolidFloor = 480;  // rows below the visible area stay solid
    localparam logic [10:0] ColsLimit  = 11'(COLS);
    localparam logic [9:0]  LastCol    = 10'(COLS - 1);

    typedef enum logic {StInit, StServe} state_e;

    state_e           state_q, state_d;
    logic [9:0]       fill_cnt_q;
    logic [9:0]       rd_addr_q;
    logic             rd_valid_q;
    logic [9:0]       draw_y_q;
    logic [DataW-1:0] data_q;
    logic [DataW-1:0] mem [COLS];

    logic             serve;
    logic             rd_in_range;
    logic             wr_en;
    logic             fwd;
    int unsigned      hill_h;
    int unsigned      ground_row;
    logic [DataW-1:0] init_col;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StInit;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (fill_cnt_q == LastCol) state_d = StServe;
            StServe: state_d = StServe;
            default: state_d = StInit;
        endcase
    end

    // State outputs
    always_comb begin
        serve    = (state_q == StServe);
        bus.busy = (state_q == StInit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 fill_cnt_q <= '0;
        else if (state_q == StInit) fill_cnt_q <= fill_cnt_q + 10'd1;
    end

    // Initial column profile for the column being filled
    always_comb begin
        hill_h = 0;
`ifdef TERRAIN_HILLS_EN
        hill_h = 32'(fill_cnt_q[5:0]);
        if (fill_cnt_q[6]) hill_h = 127 - 32'(fill_cnt_q[6:0]);
`endif
        ground_row = GROUND_Y - ((hill_h * HILL_AMP) >> 6);
        for (int unsigned y = 0; y < DataW; y++) begin
            init_col[y] = (y >= ground_row) || (y >= SolidFloor);
        end
    end

    always_comb begin
        rd_in_range = ({1'b0, bus.DrawX} < ColsLimit);
        // rd_valid_q is only set by an in-range read issued while serving
        wr_en       = serve && bus.wb_en && rd_valid_q;
        fwd         = wr_en && (bus.DrawX == rd_addr_q);
    end

    // Registered read with write-back forwarding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            draw_y_q   <= '0;
            data_q     <= '0;
        end else begin
            rd_addr_q  <= bus.DrawX;
            rd_valid_q <= serve && rd_in_range;
            draw_y_q   <= bus.DrawY;
            if (!serve || !rd_in_range) data_q <= '0;
            else if (fwd)               data_q <= bus.wb_data;
            else                        data_q <= mem[bus.DrawX];
        end
    end

    // Column RAM: fill port during init, write-back port while serving
    always_ff @(posedge clk) begin
        if (state_q == StInit) mem[fill_cnt_q] <= init_col;
        else if (wr_en)        mem[rd_addr_q]  <= bus.wb_data;
    end

    always_comb begin
        bus.terrain_data  = data_q;
        bus.terrain_pixel = draw_y_q[9] ? 1'b0 : data_q[draw_y_q[8:0]];
    end
endmodule
